// File: rtl/redmule_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NR requesters; responses are routed in order via an ID FIFO.
// Zero-cycle grant and response routing; a stalled winner stays locked until granted; requests are held off while MAX_OUT transactions are outstanding.
module redmule_tcdm_arbiter #(
  parameter int NR      = 2,
  parameter int DW      = 256,
  parameter int AW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NR-1:0]          req_i,
  output logic [NR-1:0]          gnt_o,
  input  logic [NR*AW-1:0]       add_i,
  input  logic [NR-1:0]          wen_i,
  input  logic [NR*(DW/8)-1:0]   be_i,
  input  logic [NR*DW-1:0]       data_i,
  output logic [DW-1:0]          r_data_o,
  output logic [NR-1:0]          r_valid_o,
  output logic                   tcdm_req_o,
  input  logic                   tcdm_gnt_i,
  output logic [AW-1:0]          tcdm_add_o,
  output logic                   tcdm_wen_o,
  output logic [DW/8-1:0]        tcdm_be_o,
  output logic [DW-1:0]          tcdm_data_o,
  input  logic [DW-1:0]          tcdm_r_data_i,
  input  logic                   tcdm_r_valid_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int IW = (NR > 1) ? $clog2(NR) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int BW = DW / 8;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;
  logic [IW-1:0] fifo_q [MAX_OUT];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] winner;
  logic          any_req, full, push, pop, spurious, lock_hold, lock_drop;

  assign any_req   = |req_i;
  assign full      = (cnt_q == CW'(MAX_OUT));
  assign lock_hold = lock_q & req_i[lock_id_q];
  assign lock_drop = lock_q & ~req_i[lock_id_q];

  // Round-robin search from rr_ptr; a held lock overrides the search.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int k = 0; k < NR; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NR) idx = idx - NR;
      if (!found && req_i[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
    if (lock_hold) winner = lock_id_q;
  end

  assign tcdm_req_o  = ~rst_i & any_req & ~full;
  assign push        = tcdm_req_o & tcdm_gnt_i;
  assign pop         = ~rst_i & tcdm_r_valid_i & (cnt_q != '0);
  assign spurious    = tcdm_r_valid_i & (cnt_q == '0);

  assign tcdm_add_o  = tcdm_req_o ? add_i[int'(winner)*AW +: AW]   : '0;
  assign tcdm_wen_o  = tcdm_req_o ? wen_i[winner]                  : 1'b0;
  assign tcdm_be_o   = tcdm_req_o ? be_i[int'(winner)*BW +: BW]    : '0;
  assign tcdm_data_o = tcdm_req_o ? data_i[int'(winner)*DW +: DW]  : '0;

  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = push;
  end

  always_comb begin
    r_valid_o                   = '0;
    r_valid_o[fifo_q[rd_ptr_q]] = pop;
  end

  assign r_data_o = tcdm_r_data_i;
  assign busy_o   = ~rst_i & ((cnt_q != '0) | any_req | lock_q);
  assign err_o    = err_q;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (push) begin
      rr_ptr_d = (winner == IW'(NR - 1)) ? '0 : winner + 1'b1;
      lock_d   = 1'b0;
    end else if (tcdm_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end else if (lock_drop) begin
      lock_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  assign err_d = err_q | spurious | lock_drop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Scoreboard bench for redmule_tcdm_arbiter: expected requester IDs are queued at grant and checked against r_valid_o.
module tb_redmule_tcdm_arbiter;
  localparam int NR = 2, DW = 256, AW = 32, MAX_OUT = 4, BW = DW / 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NR-1:0]        req_i, gnt_o, wen_i, r_valid_o;
  logic [NR*AW-1:0]     add_i;
  logic [NR*BW-1:0]     be_i;
  logic [NR*DW-1:0]     data_i;
  logic [DW-1:0]        r_data_o, tcdm_data_o, tcdm_r_data_i;
  logic                 tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i, busy_o, err_o;
  logic [AW-1:0]        tcdm_add_o;
  logic [BW-1:0]        tcdm_be_o;

  int checks = 0, errors = 0;
  int exp_q[$];
  logic [NR-1:0] exp_rv;
  logic [DW-1:0] d0, d1, rdat;

  redmule_tcdm_arbiter #(.NR(NR), .DW(DW), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
    .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .r_data_o(r_data_o), .r_valid_o(r_valid_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_i = '0;
    tcdm_gnt_i = 1'b0;
    tcdm_r_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 2'b11; tcdm_gnt_i = 1'b1; tcdm_r_valid_i = 1'b1;
    #2;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b exp 00", gnt_o); end
    checks++; if (tcdm_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", tcdm_req_o); end
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b exp 00", r_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    step();
    idle(); rst_i = 1'b0;
    #2;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b exp 0", busy_o); end
    checks++; if (tcdm_add_o !== '0) begin errors++; $display("FAIL rst_idle_add: got %h exp 0", tcdm_add_o); end
    step();
  endtask

  task automatic test_single();
    add_i = {32'h2000, 32'h100};
    req_i = 2'b01; tcdm_gnt_i = 1'b1;
    #2;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b exp 01", gnt_o); end
    checks++; if (tcdm_req_o !== 1'b1) begin errors++; $display("FAIL single_req: got %b exp 1", tcdm_req_o); end
    checks++; if (tcdm_add_o !== 32'h100) begin errors++; $display("FAIL single_add: got %h exp 100", tcdm_add_o); end
    checks++; if (tcdm_wen_o !== 1'b1) begin errors++; $display("FAIL single_wen: got %b exp 1", tcdm_wen_o); end
    checks++; if (tcdm_be_o !== be_i[BW-1:0]) begin errors++; $display("FAIL single_be: got %h exp %h", tcdm_be_o, be_i[BW-1:0]); end
    checks++; if (tcdm_data_o !== d0) begin errors++; $display("FAIL single_data: got %h exp %h", tcdm_data_o, d0); end
    exp_q.push_back(0);
    step();
    idle(); tcdm_r_valid_i = 1'b1; tcdm_r_data_i = {32{8'hA5}};
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL single_resp: got %b exp %b", r_valid_o, exp_rv); end
    checks++; if (r_data_o !== {32{8'hA5}}) begin errors++; $display("FAIL single_rdata: got %h exp a5..", r_data_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_resp: got %b exp 1", busy_o); end
    step();
    idle();
    #2;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b exp 0", busy_o); end
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL single_rvalid_end: got %b exp 00", r_valid_o); end
    step();
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    add_i = {32'h2000, 32'h1000};
    for (int k = 0; k < 4; k++) begin
      req_i = 2'b11; tcdm_gnt_i = 1'b1; tcdm_r_valid_i = (k > 0);
      rdat = DW'(k + 7); tcdm_r_data_i = rdat;
      #2;
      w = k % 2;
      if (k > 0) begin
        exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
        checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL rr_resp%0d: got %b exp %b", k, r_valid_o, exp_rv); end
        checks++; if (r_data_o !== rdat) begin errors++; $display("FAIL rr_rdata%0d: got %h exp %h", k, r_data_o, rdat); end
      end
      checks++; if (gnt_o !== NR'(1 << w)) begin errors++; $display("FAIL rr_gnt%0d: got %b exp %b", k, gnt_o, NR'(1 << w)); end
      checks++; if (tcdm_add_o !== ((w == 1) ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL rr_add%0d: got %h", k, tcdm_add_o); end
      exp_q.push_back(w);
      step();
    end
    idle(); tcdm_r_valid_i = 1'b1;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL rr_drain: got %b exp %b", r_valid_o, exp_rv); end
    step();
    idle(); step();
  endtask

  task automatic test_stall_lock();
    do_reset();
    req_i = 2'b11; tcdm_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (tcdm_req_o !== 1'b1 || gnt_o !== 2'b00) begin errors++; $display("FAIL stall_gnt%0d: req=%b gnt=%b exp 1/00", k, tcdm_req_o, gnt_o); end
      checks++; if (tcdm_add_o !== 32'h1000) begin errors++; $display("FAIL stall_add%0d: got %h exp 1000", k, tcdm_add_o); end
      step();
    end
    tcdm_gnt_i = 1'b1;
    #2;
    checks++; if (gnt_o !== 2'b01 || tcdm_add_o !== 32'h1000) begin errors++; $display("FAIL stall_release: gnt=%b add=%h exp 01/1000", gnt_o, tcdm_add_o); end
    exp_q.push_back(0);
    step();
    tcdm_r_valid_i = 1'b1;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL stall_resp0: got %b exp %b", r_valid_o, exp_rv); end
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL stall_next: got %b exp 10", gnt_o); end
    exp_q.push_back(1);
    step();
    // Put rr_ptr on 1, then lock requester 0 so the lock must beat round-robin.
    req_i = 2'b01;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL lock_resp1: got %b exp %b", r_valid_o, exp_rv); end
    exp_q.push_back(0);
    step();
    tcdm_gnt_i = 1'b0;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL lock_resp2: got %b exp %b", r_valid_o, exp_rv); end
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL lock_stall: got %b exp 00", gnt_o); end
    step();
    req_i = 2'b11; tcdm_gnt_i = 1'b1; tcdm_r_valid_i = 1'b0;
    #2;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_hold: got %b exp 01", gnt_o); end
    exp_q.push_back(0);
    step();
    tcdm_r_valid_i = 1'b1;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL lock_resp3: got %b exp %b", r_valid_o, exp_rv); end
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL lock_after: got %b exp 10", gnt_o); end
    exp_q.push_back(1);
    step();
    idle(); tcdm_r_valid_i = 1'b1;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL lock_drain: got %b exp %b", r_valid_o, exp_rv); end
    step();
    idle(); step();
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < MAX_OUT; k++) begin
      req_i = 2'b01; tcdm_gnt_i = 1'b1;
      #2;
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL full_fill%0d: got %b exp 01", k, gnt_o); end
      exp_q.push_back(0);
      step();
    end
    #2;
    checks++; if (tcdm_req_o !== 1'b0 || gnt_o !== 2'b00) begin errors++; $display("FAIL full_block: req=%b gnt=%b exp 0/00", tcdm_req_o, gnt_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy: got %b exp 1", busy_o); end
    step();
    tcdm_r_valid_i = 1'b1;
    #2;
    checks++; if (tcdm_req_o !== 1'b0 || gnt_o !== 2'b00) begin errors++; $display("FAIL full_pop_block: req=%b gnt=%b exp 0/00", tcdm_req_o, gnt_o); end
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL full_pop: got %b exp %b", r_valid_o, exp_rv); end
    step();
    tcdm_r_valid_i = 1'b0;
    #2;
    checks++; if (tcdm_req_o !== 1'b1 || gnt_o !== 2'b01) begin errors++; $display("FAIL full_resume: req=%b gnt=%b exp 1/01", tcdm_req_o, gnt_o); end
    exp_q.push_back(0);
    step();
    for (int k = 0; k < MAX_OUT; k++) begin
      idle(); tcdm_r_valid_i = 1'b1;
      #2;
      exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
      checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL full_drain%0d: got %b exp %b", k, r_valid_o, exp_rv); end
      step();
    end
    idle();
    #2;
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL full_end: busy=%b err=%b exp 0/0", busy_o, err_o); end
    step();
  endtask

  task automatic test_errors();
    do_reset();
    tcdm_r_valid_i = 1'b1;
    #2;
    checks++; if (r_valid_o !== 2'b00 || err_o !== 1'b0) begin errors++; $display("FAIL err_spur_now: rv=%b err=%b exp 00/0", r_valid_o, err_o); end
    step();
    tcdm_r_valid_i = 1'b0;
    #2;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_spur_set: got %b exp 1", err_o); end
    step(); step();
    #2;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", err_o); end
    do_reset();
    #2;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b exp 0", err_o); end
    req_i = 2'b01; tcdm_gnt_i = 1'b0;
    step();
    req_i = 2'b10; tcdm_gnt_i = 1'b1;
    #2;
    checks++; if (gnt_o !== 2'b10 || tcdm_add_o !== 32'h2000) begin errors++; $display("FAIL err_drop_arb: gnt=%b add=%h exp 10/2000", gnt_o, tcdm_add_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_drop_now: got %b exp 0", err_o); end
    exp_q.push_back(1);
    step();
    idle(); tcdm_r_valid_i = 1'b1;
    #2;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_drop_set: got %b exp 1", err_o); end
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL err_drop_resp: got %b exp %b", r_valid_o, exp_rv); end
    step();
    idle(); step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req_i = 2'b01; tcdm_gnt_i = 1'b1;
      step();
    end
    rst_i = 1'b1;
    #2;
    checks++; if (tcdm_req_o !== 1'b0 || gnt_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_out: req=%b gnt=%b busy=%b exp 0", tcdm_req_o, gnt_o, busy_o); end
    step();
    rst_i = 1'b0; exp_q.delete(); idle();
    #2;
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0 || r_valid_o !== 2'b00) begin errors++; $display("FAIL mid_after: busy=%b err=%b rv=%b exp 0", busy_o, err_o, r_valid_o); end
    step();
    req_i = 2'b11; tcdm_gnt_i = 1'b1;
    #2;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL mid_rr: got %b exp 01", gnt_o); end
    exp_q.push_back(0);
    step();
    req_i = 2'b10; tcdm_r_valid_i = 1'b1;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL mid_resp0: got %b exp %b", r_valid_o, exp_rv); end
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL mid_req1: got %b exp 10", gnt_o); end
    exp_q.push_back(1);
    step();
    idle(); tcdm_r_valid_i = 1'b1;
    #2;
    exp_rv = '0; if (exp_q.size() != 0) exp_rv[exp_q.pop_front()] = 1'b1;
    checks++; if (r_valid_o !== exp_rv) begin errors++; $display("FAIL mid_resp1: got %b exp %b", r_valid_o, exp_rv); end
    step();
    #2;
    checks++; if (r_valid_o !== 2'b00) begin errors++; $display("FAIL mid_spur_rv: got %b exp 00", r_valid_o); end
    step();
    idle();
    #2;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mid_spur_err: got %b exp 1", err_o); end
    step();
  endtask

  initial begin
    d0 = {8{32'hBEEF0000}};
    d1 = {8{32'hDEAD0001}};
    data_i = {d1, d0};
    be_i = {32'hF0F0F0F0, 32'h0000FFFF};
    wen_i = 2'b01;
    add_i = {32'h2000, 32'h1000};
    tcdm_r_data_i = '0;
    idle();
    rst_i = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall_lock();
    test_full();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
